// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the byte-serial load/store initiator.
//   - request size codes (byte / half / word / illegal)
//   - FSM state encoding, also exported on the debug port
//   - bytes_of(): number of byte accesses a legal size needs
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;  // illegal size code

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Byte count for a size code; the illegal code never reaches ACCESS,
  // so mapping it to 4 is harmless.
  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    case (size)
      SZ_B:    bytes_of = 3'd1;
      SZ_H:    bytes_of = 3'd2;
      default: bytes_of = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/byte_lsu_load_extend.sv
// load_extend: combinational sign/zero extension of an assembled load.
// Ports:
//   i_size     size code of the load (byte / half / word)
//   i_unsigned 1 = zero-extend, 0 = sign-extend (ignored for words)
//   i_asm      little-endian assembled bytes, lane 0 = lowest address
//   o_rdata    extended 32-bit load result
module load_extend
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_asm,
  output logic [31:0] o_rdata
);

  logic w_sign_b;
  logic w_sign_h;

  assign w_sign_b = ~i_unsigned & i_asm[7];
  assign w_sign_h = ~i_unsigned & i_asm[15];

  always_comb begin
    o_rdata = i_asm;
    case (i_size)
      SZ_B:    o_rdata = {{24{w_sign_b}}, i_asm[7:0]};
      SZ_H:    o_rdata = {{16{w_sign_h}}, i_asm[15:0]};
      default: o_rdata = i_asm;
    endcase
  end

endmodule

// File: rtl/byte_lsu.sv
// byte_lsu: CPU-side load/store initiator for a byte-wide single-port
// memory (combinational read, synchronous write). One 8/16/32-bit request
// is serialised into 1/2/4 little-endian byte accesses; loads are
// assembled and extended into a 32-bit response.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is high only in IDLE, so at most one
// request is in flight and req_valid while busy is simply ignored.
// rsp_valid is a one-cycle pulse; rsp_rdata/rsp_err hold until the next
// response.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake
//   req_we/req_size/req_unsigned     store flag, size code, zero-extend flag
//   req_addr/req_wdata               byte address, store data (low bytes)
//   rsp_valid/rsp_rdata/rsp_err      response pulse, load data, error flag
//   mem_A/mem_WE/mem_WD/mem_RD       byte memory port
//   dbg_state                        current FSM state (lsu_pkg::state_t)
module byte_lsu
  import lsu_pkg::*;
#(
  parameter int N    = 10,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [N-1:0]    req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [N-1:0]    mem_A,
  output logic            mem_WE,
  output logic [7:0]      mem_WD,
  input  logic [7:0]      mem_RD,
  output logic [1:0]      dbg_state
);

  state_t          r_state;
  logic            r_we;
  logic [1:0]      r_size;
  logic            r_uns;
  logic [N-1:0]    r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [1:0]      r_idx;
  logic [XLEN-1:0] r_asm;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic            w_req_err;
  logic            w_access;
  logic            w_last;
  logic [XLEN-1:0] w_asm_next;
  logic [XLEN-1:0] w_ext;

  // Misaligned halves/words and the illegal size code are rejected at accept.
  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      SZ_B:    w_req_err = 1'b0;
      SZ_H:    w_req_err = req_addr[0];
      SZ_W:    w_req_err = |req_addr[1:0];
      default: w_req_err = 1'b1;
    endcase
  end

  assign w_access = (r_state == ST_ACCESS);
  assign w_last   = ({1'b0, r_idx} == (bytes_of(r_size) - 3'd1));

  // Assembly register with the current byte merged in. The response is
  // extended from this so the last byte does not cost an extra cycle.
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{r_idx, 3'b000} +: 8] = mem_RD;
  end

  load_extend u_load_extend (
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_asm      (w_asm_next),
    .o_rdata    (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_size  <= SZ_B;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_idx   <= 2'd0;
      r_asm   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_idx   <= 2'd0;
            r_asm   <= '0;
            if (w_req_err) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!r_we) r_asm <= w_asm_next;
          r_idx <= r_idx + 2'd1;
          if (w_last) begin
            r_err   <= 1'b0;
            r_rdata <= r_we ? '0 : w_ext;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port is decoded from registered state only; outside ACCESS it
  // is forced to zero, and reset drops mem_WE asynchronously.
  assign mem_A  = w_access ? (r_addr + N'(r_idx)) : '0;
  assign mem_WE = w_access & r_we;
  assign mem_WD = w_access ? r_wdata[{r_idx, 3'b000} +: 8] : 8'h00;

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_byte_lsu.sv
// Directed bench for byte_lsu with a byte-wide memory model and
// hand-computed expected values.
module tb_byte_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  mem_A;
  logic        mem_WE;
  logic [7:0]  mem_WD;
  logic [7:0]  mem_RD;
  logic [1:0]  dbg_state;

  logic [7:0]  mem [0:1023];
  logic        init_mem;

  int n_checks = 0;
  int n_errors = 0;

  byte_lsu #(.N(10), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_A        (mem_A),
    .mem_WE       (mem_WE),
    .mem_WD       (mem_WD),
    .mem_RD       (mem_RD),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  assign mem_RD = mem[mem_A];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h010] <= 8'h80;
      mem[10'h011] <= 8'h81;
      mem[10'h012] <= 8'h82;
      mem[10'h013] <= 8'h83;
    end else if (mem_WE) begin
      mem[mem_A] <= mem_WD;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge while idle. nb = expected byte accesses (0 = error).
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [9:0] addr, input logic [31:0] wdata,
                        input int nb, input logic [31:0] exp_rdata, input logic exp_err);
    logic [9:0] ea;
    logic [7:0] eb;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    chk({tag, " ready_before"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    for (int c = 1; c <= nb; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      ea = addr + 10'(c - 1);
      eb = wdata[8*(c-1) +: 8];
      chk({tag, " mem_A"},  32'(mem_A),  32'(ea));
      chk({tag, " mem_WE"}, 32'(mem_WE), 32'(we));
      if (we) chk({tag, " mem_WD"}, 32'(mem_WD), 32'(eb));
      chk({tag, " busy_ready"}, 32'(req_ready), 32'd0);
      chk({tag, " busy_rsp"},   32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    if (nb == 0) req_valid = 1'b0;
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, " rsp_err"},   32'(rsp_err), 32'(exp_err));
    chk({tag, " resp_ready"}, 32'(req_ready), 32'd0);
    chk({tag, " resp_WE"},    32'(mem_WE), 32'd0);
    @(negedge clk);
    chk({tag, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, " idle_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " hold_rdata"}, rsp_rdata, exp_rdata);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    init_mem     = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 10'h000;
    req_wdata    = 32'h0;
    repeat (2) @(negedge clk);
    init_mem = 1'b0;

    // reset values
    chk("rst state",  32'(dbg_state), 32'd0);
    chk("rst ready",  32'(req_ready), 32'd1);
    chk("rst rsp_v",  32'(rsp_valid), 32'd0);
    chk("rst rsp_e",  32'(rsp_err),   32'd0);
    chk("rst rdata",  rsp_rdata,      32'h0);
    chk("rst mem_A",  32'(mem_A),     32'h0);
    chk("rst mem_WE", 32'(mem_WE),    32'd0);
    chk("rst mem_WD", 32'(mem_WD),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // loads and extension
    do_req("lw010",  1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 4, 32'h83828180, 1'b0);
    do_req("lb010",  1'b0, 2'b00, 1'b0, 10'h010, 32'h0, 1, 32'hFFFFFF80, 1'b0);
    do_req("lbu010", 1'b0, 2'b00, 1'b1, 10'h010, 32'h0, 1, 32'h00000080, 1'b0);
    do_req("lh012",  1'b0, 2'b01, 1'b0, 10'h012, 32'h0, 2, 32'hFFFF8382, 1'b0);
    do_req("lhu012", 1'b0, 2'b01, 1'b1, 10'h012, 32'h0, 2, 32'h00008382, 1'b0);

    // store then read back
    do_req("sw020", 1'b1, 2'b10, 1'b0, 10'h020, 32'hDEADBEEF, 4, 32'h0, 1'b0);
    chk("mem020", 32'(mem[10'h020]), 32'hEF);
    chk("mem021", 32'(mem[10'h021]), 32'hBE);
    chk("mem022", 32'(mem[10'h022]), 32'hAD);
    chk("mem023", 32'(mem[10'h023]), 32'hDE);
    do_req("lw020", 1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 4, 32'hDEADBEEF, 1'b0);

    // error cases: response one cycle after accept, no writes
    do_req("err_lh011", 1'b0, 2'b01, 1'b0, 10'h011, 32'h0,        0, 32'h0, 1'b1);
    do_req("err_sw022", 1'b1, 2'b10, 1'b0, 10'h022, 32'h12345678, 0, 32'h0, 1'b1);
    do_req("err_sz11",  1'b1, 2'b11, 1'b0, 10'h040, 32'hA5A5A5A5, 0, 32'h0, 1'b1);
    chk("err_nowrite022", 32'(mem[10'h022]), 32'hAD);
    chk("err_nowrite040", 32'(mem[10'h040]), 32'h00);

    // req_valid held across two lw requests
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 10'h010; req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("b2b ready0_a", 32'(req_ready), 32'd0);
      if (c == 5) begin
        chk("b2b rsp_a",   32'(rsp_valid), 32'd1);
        chk("b2b data_a",  rsp_rdata, 32'h83828180);
        chk("b2b err_a",   32'(rsp_err), 32'd0);
      end
    end
    @(negedge clk);
    chk("b2b idle_ready", 32'(req_ready), 32'd1);
    chk("b2b idle_rsp",   32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b accept2_state", 32'(dbg_state), 32'd1);
    chk("b2b accept2_A",     32'(mem_A), 32'h010);
    chk("b2b ready0_b",      32'(req_ready), 32'd0);
    // changing inputs after accept must not matter
    req_valid = 1'b0; req_addr = 10'h020; req_size = 2'b00;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk("b2b A_b",     32'(mem_A), 32'(10'h010 + 10'(c - 1)));
      chk("b2b ready0_b", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    chk("b2b rsp_b",  32'(rsp_valid), 32'd1);
    chk("b2b data_b", rsp_rdata, 32'h83828180);
    @(negedge clk);
    chk("b2b end_ready", 32'(req_ready), 32'd1);
    chk("b2b end_rsp",   32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("b2b stay_idle", 32'(dbg_state), 32'd0);

    // reset in the middle of sw 0x030
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 10'h030; req_wdata = 32'h11223344; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mrst WD0", 32'(mem_WD), 32'h44);
    @(negedge clk);
    chk("mrst WD1", 32'(mem_WD), 32'h33);
    @(negedge clk);
    chk("mrst WE_before", 32'(mem_WE), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst WE",    32'(mem_WE),    32'd0);
    chk("mrst A",     32'(mem_A),     32'h0);
    chk("mrst WD",    32'(mem_WD),    32'h0);
    chk("mrst ready", 32'(req_ready), 32'd1);
    chk("mrst rsp_v", 32'(rsp_valid), 32'd0);
    chk("mrst rdata", rsp_rdata,      32'h0);
    chk("mrst state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mrst no_rsp",  32'(rsp_valid), 32'd0);
      chk("mrst ready_r", 32'(req_ready), 32'd1);
    end
    chk("mrst mem030", 32'(mem[10'h030]), 32'h44);
    chk("mrst mem031", 32'(mem[10'h031]), 32'h33);
    chk("mrst mem032", 32'(mem[10'h032]), 32'h00);
    chk("mrst mem033", 32'(mem[10'h033]), 32'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
